clahe_divider_stream: RTL

- Parametrised successor of the CLAHE 32/32 pipelined divider.
- Restoring shift-subtract unsigned divider with independent dividend/divisor widths, configurable quotient bits per pipeline stage, and valid/ready backpressure.
- Carries a sideband tag and flags divide-by-zero.
- Sits between the CLAHE CDF/histogram logic and the mapping-LUT writer, where the consumer can stall.

---
 rtl/clahe_div_pkg.sv | 25 ++
 rtl/clahe_divider_stream_stage.sv | 80 ++++++++
 rtl/clahe_divider_stream.sv | 132 +++++++++++++
 3 files changed

// File: rtl/clahe_div_pkg.sv
// Shared constants and helpers for the CLAHE streaming restoring divider.
// The default-configuration constants describe the 32/16 instance that feeds the mapping LUT.
package clahe_div_pkg;

    localparam int DEF_DIVIDEND_WIDTH = 32;
    localparam int DEF_DIVISOR_WIDTH  = 16;
    localparam int DEF_BITS_PER_STAGE = 1;
    localparam int DEF_TAG_WIDTH      = 8;

    // Widest dividend the all-ones divide-by-zero quotient constant covers
    localparam int MAX_DIVIDEND_WIDTH = 64;
    localparam logic [MAX_DIVIDEND_WIDTH-1:0] DBZ_QUOTIENT_MAX = '1;

    function automatic int div_nstg(input int dividend_width, input int bits_per_stage);
        return dividend_width / bits_per_stage;
    endfunction

    function automatic int div_latency(input int dividend_width, input int bits_per_stage);
        return div_nstg(dividend_width, bits_per_stage) + 1;
    endfunction

    localparam int NSTG  = div_nstg(DEF_DIVIDEND_WIDTH, DEF_BITS_PER_STAGE);
    localparam int REM_W = DEF_DIVISOR_WIDTH + 1;

endpackage

// File: rtl/clahe_divider_stream_stage.sv
// One register stage of the restoring divider: resolves BITS_PER_STAGE quotient bits
// combinationally, then registers the partial result together with its sideband.
module clahe_div_stage
    import clahe_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
    parameter int BITS_PER_STAGE = DEF_BITS_PER_STAGE,
    parameter int TAG_WIDTH      = DEF_TAG_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      prev_valid,
    input  logic [DIVIDEND_WIDTH-1:0] prev_work,
    input  logic [DIVISOR_WIDTH-1:0]  prev_rem,
    input  logic [DIVISOR_WIDTH-1:0]  prev_div,
    input  logic [TAG_WIDTH-1:0]      prev_tag,
    input  logic                      prev_dbz,
    output logic                      valid,
    output logic [DIVIDEND_WIDTH-1:0] work,
    output logic [DIVISOR_WIDTH-1:0]  rem,
    output logic [DIVISOR_WIDTH-1:0]  div,
    output logic [TAG_WIDTH-1:0]      tag,
    output logic                      dbz
);

    localparam int RW = DIVISOR_WIDTH + 1;

    // work holds the unconsumed dividend bits in its MSBs and the quotient bits resolved
    // so far in its LSBs. The trial remainder needs RW bits, but after each step it is
    // below the divisor, so DIVISOR_WIDTH bits are enough to register it. With a zero
    // divisor the truncation leaves exactly the low dividend bits as the remainder.
    logic [DIVIDEND_WIDTH-1:0] work_nxt;
    logic [DIVISOR_WIDTH-1:0]  rem_nxt;
    logic [RW-1:0]             trial;

    always_comb begin
        work_nxt = prev_work;
        rem_nxt  = prev_rem;
        trial    = '0;
        for (int i = 0; i < BITS_PER_STAGE; i++) begin
            trial = {rem_nxt, work_nxt[DIVIDEND_WIDTH-1]};
            if (trial >= {1'b0, prev_div}) begin
                trial    = trial - {1'b0, prev_div};
                work_nxt = {work_nxt[DIVIDEND_WIDTH-2:0], 1'b1};
            end else begin
                work_nxt = {work_nxt[DIVIDEND_WIDTH-2:0], 1'b0};
            end
            rem_nxt = trial[DIVISOR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            work  <= '0;
            rem   <= '0;
            div   <= '0;
            tag   <= '0;
            dbz   <= 1'b0;
        end else if (en) begin
            valid <= prev_valid;
            if (prev_valid) begin
                work <= work_nxt;
                rem  <= rem_nxt;
                div  <= prev_div;
                tag  <= prev_tag;
                dbz  <= prev_dbz;
            end else begin
                work <= '0;
                rem  <= '0;
                div  <= '0;
                tag  <= '0;
                dbz  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clahe_divider_stream.sv
// Streaming restoring unsigned divider for CLAHE: input register, NSTG compute stages,
// one global advance enable driven by the output handshake.
module clahe_divider_stream
    import clahe_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
    parameter int BITS_PER_STAGE = DEF_BITS_PER_STAGE,
    parameter int TAG_WIDTH      = DEF_TAG_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] in_dividend,
    input  logic [DIVISOR_WIDTH-1:0]  in_divisor,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] out_quotient,
    output logic [DIVISOR_WIDTH-1:0]  out_remainder,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic                      out_dbz
);

    localparam int STAGES = div_latency(DIVIDEND_WIDTH, BITS_PER_STAGE) - 1;
    localparam int LAST   = STAGES - 1;

    if (BITS_PER_STAGE < 1 || DIVIDEND_WIDTH < 2 || DIVISOR_WIDTH < 1 || TAG_WIDTH < 1 ||
        DIVISOR_WIDTH > DIVIDEND_WIDTH || DIVIDEND_WIDTH > MAX_DIVIDEND_WIDTH ||
        (DIVIDEND_WIDTH % BITS_PER_STAGE) != 0) begin : g_bad_params
        $error("clahe_divider_stream: illegal parameter combination");
    end

    logic adv;

    logic                      s_valid;
    logic [DIVIDEND_WIDTH-1:0] s_dividend;
    logic [DIVISOR_WIDTH-1:0]  s_divisor;
    logic [TAG_WIDTH-1:0]      s_tag;
    logic                      s_dbz;

    logic                      st_valid [STAGES];
    logic [DIVIDEND_WIDTH-1:0] st_work  [STAGES];
    logic [DIVISOR_WIDTH-1:0]  st_rem   [STAGES];
    logic [DIVISOR_WIDTH-1:0]  st_div   [STAGES];
    logic [TAG_WIDTH-1:0]      st_tag   [STAGES];
    logic                      st_dbz   [STAGES];

    // A single enable keeps every stage in lockstep; bubbles are deliberately not collapsed.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid    <= 1'b0;
            s_dividend <= '0;
            s_divisor  <= '0;
            s_tag      <= '0;
            s_dbz      <= 1'b0;
        end else if (adv) begin
            s_valid <= in_valid;
            if (in_valid) begin
                s_dividend <= in_dividend;
                s_divisor  <= in_divisor;
                s_tag      <= in_tag;
                s_dbz      <= (in_divisor == '0);
            end else begin
                s_dividend <= '0;
                s_divisor  <= '0;
                s_tag      <= '0;
                s_dbz      <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic                      p_valid;
        logic [DIVIDEND_WIDTH-1:0] p_work;
        logic [DIVISOR_WIDTH-1:0]  p_rem;
        logic [DIVISOR_WIDTH-1:0]  p_div;
        logic [TAG_WIDTH-1:0]      p_tag;
        logic                      p_dbz;

        if (g == 0) begin : g_first
            assign p_valid = s_valid;
            assign p_work  = s_dividend;
            assign p_rem   = '0;
            assign p_div   = s_divisor;
            assign p_tag   = s_tag;
            assign p_dbz   = s_dbz;
        end else begin : g_chain
            assign p_valid = st_valid[g-1];
            assign p_work  = st_work[g-1];
            assign p_rem   = st_rem[g-1];
            assign p_div   = st_div[g-1];
            assign p_tag   = st_tag[g-1];
            assign p_dbz   = st_dbz[g-1];
        end

        clahe_div_stage #(
            .DIVIDEND_WIDTH (DIVIDEND_WIDTH),
            .DIVISOR_WIDTH  (DIVISOR_WIDTH),
            .BITS_PER_STAGE (BITS_PER_STAGE),
            .TAG_WIDTH      (TAG_WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (adv),
            .prev_valid (p_valid),
            .prev_work  (p_work),
            .prev_rem   (p_rem),
            .prev_div   (p_div),
            .prev_tag   (p_tag),
            .prev_dbz   (p_dbz),
            .valid      (st_valid[g]),
            .work       (st_work[g]),
            .rem        (st_rem[g]),
            .div        (st_div[g]),
            .tag        (st_tag[g]),
            .dbz        (st_dbz[g])
        );
    end

    // The arithmetic already yields all ones for a zero divisor; the mux pins it explicitly.
    assign out_valid     = st_valid[LAST];
    assign out_quotient  = st_dbz[LAST] ? DBZ_QUOTIENT_MAX[DIVIDEND_WIDTH-1:0] : st_work[LAST];
    assign out_remainder = st_rem[LAST];
    assign out_tag       = st_tag[LAST];
    assign out_dbz       = st_dbz[LAST];

endmodule
